// File: rtl/sh2_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sh2_bus_arbiter
//
// Arbitrates the shared external system bus between the master SH7604 (the
// parked owner), the slave SH7604 and one external DMA master. The master is
// asked to let go of the bus through its BRLS_N pin and confirms with BGR_N.
// The slave CPU's BGR_N pin is used as its bus request, and its BRLS_N pin is
// used as the acknowledge. OWNER tells the top level which requester's
// address, data and strobes to steer onto the shared bus.
//
// Ports
//   CLK, RST_N   system clock, asynchronous active-low reset
//   CE_R         clock enable; state advances only on CE_R=1
//   EN           run enable; state is frozen while 0
//   RES_N        synchronous soft reset, active low, qualified by CE_R
//   MSH_BRLS_N   release request to the master CPU (0 = please release)
//   MSH_BGR_N    master CPU grant (0 = bus released)
//   SSH_BREQ_N   slave CPU bus request (active low)
//   SSH_BACK_N   slave CPU bus acknowledge (active low)
//   EXT_REQ      external DMA request (level)
//   EXT_LOCK     external DMA keeps the bus regardless of EXT_REQ
//   EXT_GNT      external DMA grant
//   OWNER        0 master, 1 slave, 2 external, 3 none/turnaround
//   TMO_IRQ      one-CE-cycle pulse when a waiting requester hits HOLD_MAX
// -----------------------------------------------------------------------------
module sh2_bus_arbiter #(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       EN,
  input  logic       RES_N,
  output logic       MSH_BRLS_N,
  input  logic       MSH_BGR_N,
  input  logic       SSH_BREQ_N,
  output logic       SSH_BACK_N,
  input  logic       EXT_REQ,
  input  logic       EXT_LOCK,
  output logic       EXT_GNT,
  output logic [1:0] OWNER,
  output logic       TMO_IRQ
);

  typedef enum logic [2:0] {
    M_OWN,  // master owns the bus (parked)
    REL,    // release requested from master, waiting for its grant
    DEAD,   // turnaround after the master released; winner picked here
    S_OWN,  // slave CPU owns the bus
    E_OWN,  // external DMA owns the bus
    DEAD2,  // turnaround after a non-master owner released
    RET     // bus being handed back, waiting for master to take it
  } state_t;

  localparam logic [1:0] OWN_MASTER = 2'd0;
  localparam logic [1:0] OWN_SLAVE  = 2'd1;
  localparam logic [1:0] OWN_EXT    = 2'd2;
  localparam logic [1:0] OWN_NONE   = 2'd3;

  localparam logic [9:0] HOLD_SAT  = 10'h3FF;
  localparam logic [9:0] HOLD_LAST = 10'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic       last_ext_q, last_ext_d;  // 1: external was served last, slave is next
  logic [9:0] hold_q, hold_d;
  logic       tmo_d;
  logic       hold_run;                // the other non-master is waiting this cycle

  logic       pend_s, pend_e;
  assign pend_s = !SSH_BREQ_N;
  assign pend_e = EXT_REQ;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    last_ext_d = last_ext_q;
    hold_d     = hold_q;
    tmo_d      = 1'b0;
    hold_run   = 1'b0;

    unique case (state_q)
      M_OWN: if (pend_s || pend_e) state_d = REL;

      // A grant that arrives together with the requests vanishing still
      // proceeds: the master has already let go, DEAD will route to RET.
      REL: begin
        if (!MSH_BGR_N)              state_d = DEAD;
        else if (!pend_s && !pend_e) state_d = M_OWN;
      end

      DEAD: begin
        if (pend_s && (!pend_e || (RR_EN && last_ext_q))) begin
          state_d    = S_OWN;
          last_ext_d = 1'b0;
          hold_d     = '0;
        end else if (pend_e) begin
          state_d    = E_OWN;
          last_ext_d = 1'b1;
          hold_d     = '0;
        end else begin
          state_d = RET;
        end
      end

      S_OWN: begin
        if (SSH_BREQ_N) state_d = DEAD2;
        else            hold_run = pend_e;
      end

      E_OWN: begin
        if (!EXT_REQ && !EXT_LOCK) state_d = DEAD2;
        else                       hold_run = pend_s;
      end

      // last_ext_q still names the owner that just left, so the "other"
      // requester is the one it does not point at.
      DEAD2: begin
        if (last_ext_q && pend_s) begin
          state_d    = S_OWN;
          last_ext_d = 1'b0;
          hold_d     = '0;
        end else if (!last_ext_q && pend_e) begin
          state_d    = E_OWN;
          last_ext_d = 1'b1;
          hold_d     = '0;
        end else begin
          state_d = RET;
        end
      end

      RET: if (MSH_BGR_N) state_d = M_OWN;

      default: state_d = M_OWN;
    endcase

    // Saturating hold counter; the interrupt fires only on the step that
    // reaches HOLD_MAX, so it cannot repeat while the count sits there.
    if (hold_run && hold_q != HOLD_SAT) begin
      hold_d = hold_q + 10'd1;
      tmo_d  = (hold_q == HOLD_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs (outputs decoded from the next state so they
  // change on the same edge as the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RST_N) begin
      state_q    <= M_OWN;
      last_ext_q <= 1'b1;
      hold_q     <= '0;
      MSH_BRLS_N <= 1'b1;
      SSH_BACK_N <= 1'b1;
      EXT_GNT    <= 1'b0;
      OWNER      <= OWN_MASTER;
      TMO_IRQ    <= 1'b0;
    end else if (CE_R) begin
      if (!RES_N) begin
        state_q    <= M_OWN;
        last_ext_q <= 1'b1;
        hold_q     <= '0;
        MSH_BRLS_N <= 1'b1;
        SSH_BACK_N <= 1'b1;
        EXT_GNT    <= 1'b0;
        OWNER      <= OWN_MASTER;
        TMO_IRQ    <= 1'b0;
      end else if (EN) begin
        state_q    <= state_d;
        last_ext_q <= last_ext_d;
        hold_q     <= hold_d;
        MSH_BRLS_N <= (state_d == M_OWN) || (state_d == RET);
        SSH_BACK_N <= (state_d != S_OWN);
        EXT_GNT    <= (state_d == E_OWN);
        TMO_IRQ    <= tmo_d;
        unique case (state_d)
          M_OWN:   OWNER <= OWN_MASTER;
          S_OWN:   OWNER <= OWN_SLAVE;
          E_OWN:   OWNER <= OWN_EXT;
          default: OWNER <= OWN_NONE;
        endcase
      end
    end
  end

endmodule

// File: doc/sh2_bus_arbiter.md
Name: sh2_bus_arbiter

Overview:
- Arbitrates the shared external system bus between three requesters:
  - master SH7604 (default/parked owner)
  - slave SH7604
  - one external DMA master
- Drives the master CPU's BRLS_N input and consumes its BGR_N output (bus-release handshake).
- Slave CPU side: takes its BGR_N pin as a bus request (BREQ_N) and drives its BRLS_N pin as acknowledge (BACK_N).
- Produces an owner code used by the top level to steer the shared address, data and strobe mux.

Parameters:
- RR_EN, 1: 1 = round-robin tie-break between slave and external DMA; 0 = external DMA always wins ties.
- HOLD_MAX, 255: CE cycles a non-master owner may hold the bus while another non-master requester waits before TMO_IRQ pulses. Range 1..1023.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  async reset, active low
- CE_R  in  1  clock enable; all state advances only when CE_R=1
- EN  in  1  global run enable; when 0, state frozen
- RES_N  in  1  synchronous soft reset, active low (qualified by CE_R)
- MSH_BRLS_N  out  1  release request to master CPU BRLS_N
- MSH_BGR_N  in  1  master CPU grant (0 = bus released)
- SSH_BREQ_N  in  1  slave CPU bus request (its BGR_N pin)
- SSH_BACK_N  out  1  slave acknowledge (its BRLS_N pin)
- EXT_REQ  in  1  external DMA request, level
- EXT_LOCK  in  1  external DMA holds bus regardless of EXT_REQ
- EXT_GNT  out  1  external DMA grant
- OWNER  out  2  0 = master, 1 = slave, 2 = external, 3 = none/turnaround
- TMO_IRQ  out  1  one-CE-cycle pulse on hold-limit overrun

Behaviour:
- Reset: RST_N is asynchronous, active-low; clock is CLK.
- Outputs at reset: MSH_BRLS_N=1, SSH_BACK_N=1, EXT_GNT=0, OWNER=0, TMO_IRQ=0, state M_OWN, hold counter=0, RR pointer=slave-next.
- RES_N=0 on a CE_R cycle forces the same values synchronously, even mid-ownership. Any grant is dropped immediately.
- All transitions and sampling occur on CE_R=1 && EN=1. Registered outputs change on the same edge as the state.
- pend_s = !SSH_BREQ_N; pend_e = EXT_REQ.
- States and transitions:
  - M_OWN: OWNER=0. If pend_s or pend_e, go to REL and drive MSH_BRLS_N=0 (next edge).
  - REL: MSH_BRLS_N=0, OWNER=3.
    - Wait for MSH_BGR_N=0, then go to DEAD.
    - If all requests vanish before the grant, return to M_OWN with MSH_BRLS_N=1.
  - DEAD: one turnaround cycle, OWNER=3. Winner is chosen at this edge:
    - only one pending: that requester wins
    - both pending, RR_EN=0: external wins
    - both pending, RR_EN=1: the requester not served last wins
    - none pending: go to RET
  - S_OWN: SSH_BACK_N=0, OWNER=1. When SSH_BREQ_N=1, go to DEAD2 with SSH_BACK_N=1.
  - E_OWN: EXT_GNT=1, OWNER=2. When EXT_REQ=0 and EXT_LOCK=0, go to DEAD2 with EXT_GNT=0.
  - DEAD2: one turnaround cycle, OWNER=3.
    - If the other requester is pending, grant it (handoff without returning the bus to the master).
    - Otherwise go to RET.
  - RET: MSH_BRLS_N=1, OWNER=3. Wait for MSH_BGR_N=1, then go to M_OWN.
    - A request arriving in RET is not serviced until M_OWN is re-entered (no short-circuit).
- Latency, request to grant (MSH_BGR_N answering in the same cycle): request edge n → MSH_BRLS_N=0 at n+1 → DEAD at n+2 → grant at n+3.
- Hold counter:
  - Clears on entry to S_OWN/E_OWN; increments each CE cycle while the other non-master is pending.
  - Saturates at 1023.
  - TMO_IRQ pulses once when the count equals HOLD_MAX. No preemption; the owner keeps the bus.
- Protocol error: MSH_BGR_N rising while in S_OWN/E_OWN/DEAD/DEAD2 is ignored; MSH_BRLS_N stays 0.
- Never more than one of (OWNER=0 with MSH_BRLS_N=1), SSH_BACK_N=0, EXT_GNT=1 is true at once.

Test Plan:
- Reset → MSH_BRLS_N=1, SSH_BACK_N=1, EXT_GNT=0, OWNER=0. Deassert RST_N and idle 10 cycles → no change.
- SSH_BREQ_N=0 at CE edge 0, master answers MSH_BGR_N=0 immediately → MSH_BRLS_N=0 at edge 1, SSH_BACK_N=0 and OWNER=1 at edge 3.
  - Then SSH_BREQ_N=1 → SSH_BACK_N=1, then MSH_BRLS_N=1; after MSH_BGR_N=1, OWNER=0.
- Slave and EXT request simultaneously, RR_EN=1, last served = ext → slave granted first.
  - Slave releases → EXT_GNT=1 after exactly one DEAD2 cycle, with no MSH_BRLS_N toggle.
- HOLD_MAX=4: EXT owns with EXT_LOCK=1 while slave waits → TMO_IRQ high for exactly one CE cycle, 4 cycles after the slave request; EXT_GNT stays 1.
- RES_N=0 during E_OWN → next CE edge: EXT_GNT=0, MSH_BRLS_N=1, OWNER=0.
- CE_R low every other cycle and EN=0 for 5 cycles mid-REL → state and outputs frozen; transitions counted in CE cycles only.
